hpf_channel_scheduler: RTL and testbench
========================================

Name: hpf_channel_scheduler

Overview:
- Time-multiplexes one leaky RC high-pass update datapath across NUM_CHANNELS independent audio channels.
- On each audio_clk_en tick it snapshots all channel inputs, then sequences the channels one at a time through a shared multiply pipeline. It publishes all outputs together with a one-cycle valid strobe.
- Per-channel coefficients (alpha, leak) are runtime-configurable. This lets a sound board instantiate many discrete high-pass stages for the cost of one multiplier pair.

Parameters:
- NUM_CHANNELS, 4, number of filter channels (1..16).
- CLOCK_RATE, 50000000, system clock in Hz.
- SAMPLE_RATE, 48000, audio_clk_en rate in Hz.
- DEFAULT_ALPHA_16_SHIFTED, 65527, alpha reset value (unsigned, 16 fractional bits; 47k/3.3uF at 48 kHz).
- DEFAULT_LEAK_16_SHIFTED, 65039, leak reset value (unsigned, 16 fractional bits).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- audio_clk_en  in  1  sample tick, one-cycle pulse
- in_samples  in  16*NUM_CHANNELS  signed inputs, channel k at [16k+15:16k]
- cfg_we  in  1  coefficient write strobe
- cfg_chan  in  4  channel index for the write
- cfg_alpha  in  17  new alpha (0..65536)
- cfg_leak  in  17  new leak (0..65536)
- out_samples  out  16*NUM_CHANNELS  signed filtered outputs, same packing as in_samples
- out_valid  out  1  one-cycle pulse when out_samples updates
- busy  out  1  high while a sequence runs
- overrun  out  1  sticky; a tick arrived while busy

Behaviour:
- Reset (synchronous, active-high):
  - All x_prev, y_prev, out_samples, snapshots, out_valid, busy and overrun go to 0.
  - Active and shadow alpha/leak load their defaults. FSM goes to IDLE.
  - Reset mid-sequence aborts immediately; no partial output is published.
- Coefficient writes:
  - cfg_we writes the shadow alpha/leak of cfg_chan.
  - cfg_chan >= NUM_CHANNELS is ignored.
  - Shadows copy to the active set only at an accepted tick, so a sequence always uses consistent coefficients.
  - A write coincident with an accepted tick is included in that tick's copy.
- FSM states: IDLE, LOAD, MUL1, MUL2, STORE, DONE.
  - IDLE + audio_clk_en: snapshot in_samples, copy shadows, chan=0, busy=1 -> LOAD.
  - LOAD: fetch snapshot x, x_prev, y_prev, alpha, leak for chan; issue stage 1 -> MUL1.
  - MUL1: p = (leak * y_prev) >>> 16; s = p + x - x_prev (19-bit signed) -> MUL2.
  - MUL2: q = (alpha * s) >>> 16 -> STORE.
  - STORE: y = sat16(q); y_prev[chan]=y; x_prev[chan]=x; result[chan]=y. If chan==NUM_CHANNELS-1 -> DONE, else chan++ -> LOAD.
  - DONE: out_samples <= results (all channels at once), out_valid=1 for this cycle only, busy=0 -> IDLE.
- Latency: tick at cycle T gives out_valid at cycle T+4*NUM_CHANNELS+1 (T+17 for 4 channels).
- Timing requirement: 4*NUM_CHANNELS+2 <= CLOCK_RATE/SAMPLE_RATE, checked by an elaboration-time assertion.
- Arithmetic:
  - Multiplies are signed 17x19 with arithmetic right shifts.
  - sat16 clamps to [-32768, 32767]; there is no wrap-around.
- Overrun:
  - audio_clk_en while busy (states other than IDLE) is dropped and sets overrun=1.
  - overrun clears only on reset.
- out_samples holds its value between out_valid pulses.

Decomposition:
- Package hpf_sched_pkg holds:
  - state enum (IDLE..DONE)
  - SAMPLE_W=16, COEF_W=17, SUM_W=19
  - sat16 function
  - CYCLES_PER_CHANNEL=4
- Sub-module hpf_update_datapath: the two-stage leak/alpha multiply pipeline with saturation, stateless apart from pipeline registers. The scheduler owns the FSM, the state RAM and the coefficient registers.

Test Plan:
- Reset -> out_samples all 0; busy, out_valid and overrun all 0. cfg readback via a run with zero input gives all outputs 0.
- Unity differentiator (ch0 alpha=65536, leak=65536): input 0 then 1000 on two ticks -> outputs 0, then 1000; a third tick at 1000 -> 1000 (held).
- Saturation (ch1 alpha=65536, leak=0): input -32768 then 32767 -> second output 32767, not wrapped.
- Latency/strobe (N=4): tick at T -> out_valid high only at T+17, busy high T+1..T+16.
- Overrun: second tick at T+5 -> dropped, overrun=1 and stays 1. The next tick after DONE is processed normally.
- Mid-run reset and shadow timing: cfg write to ch2 during busy -> not used until the next tick. Reset at T+8 -> no out_valid; all state returns to 0 and defaults.

Source files
------------

// File: rtl/hpf_sched_pkg.sv
// Shared widths, FSM encodings and saturation helper for the multiplexed high-pass scheduler.
package hpf_sched_pkg;

    localparam int unsigned SAMPLE_W           = 16;
    localparam int unsigned COEF_W             = 17;
    localparam int unsigned SUM_W              = 19;
    localparam int unsigned CYCLES_PER_CHANNEL = 4;

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StLoad  = 3'd1;
    localparam state_t StMul1  = 3'd2;
    localparam state_t StMul2  = 3'd3;
    localparam state_t StStore = 3'd4;
    localparam state_t StDone  = 3'd5;

    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [SUM_W-1:0] v);
        if (v > 19'sd32767) begin
            return 16'sh7fff;
        end else if (v < -19'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[SAMPLE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/hpf_channel_scheduler_if.sv
// Sample, coefficient-write and result bundle between the scheduler and its host.
interface hpf_channel_scheduler_if #(
    parameter int unsigned NUM_CHANNELS = 4
);
    logic                        audio_clk_en;
    logic [16*NUM_CHANNELS-1:0]  in_samples;
    logic                        cfg_we;
    logic [3:0]                  cfg_chan;
    logic [16:0]                 cfg_alpha;
    logic [16:0]                 cfg_leak;
    logic [16*NUM_CHANNELS-1:0]  out_samples;
    logic                        out_valid;
    logic                        busy;
    logic                        overrun;

    modport master (
        output audio_clk_en, in_samples, cfg_we, cfg_chan, cfg_alpha, cfg_leak,
        input  out_samples, out_valid, busy, overrun
    );

    modport slave (
        input  audio_clk_en, in_samples, cfg_we, cfg_chan, cfg_alpha, cfg_leak,
        output out_samples, out_valid, busy, overrun
    );
endinterface

// File: rtl/hpf_update_datapath.sv
// Two-stage leaky high-pass update: s = (leak*y_prev >>> 16) + x - x_prev, y = sat16(alpha*s >>> 16).
module hpf_update_datapath
    import hpf_sched_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [SAMPLE_W-1:0] x_i,
    input  logic signed [SAMPLE_W-1:0] x_prev_i,
    input  logic signed [SAMPLE_W-1:0] y_prev_i,
    input  logic        [COEF_W-1:0]   alpha_i,
    input  logic        [COEF_W-1:0]   leak_i,
    output logic signed [SAMPLE_W-1:0] y_o
);

    logic signed [SAMPLE_W-1:0] x_q, xp_q, yp_q, y_q;
    logic        [COEF_W-1:0]   alpha_q, leak_q, alpha1_q;
    logic signed [SUM_W-1:0]    s_q, s_d, p, q;
    logic signed [33:0]         p_full;
    logic signed [36:0]         q_full;

    // Coefficients are unsigned 0..65536, so zero-extend before the signed multiply.
    assign p_full = 34'($signed({1'b0, leak_q})) * 34'(yp_q);
    assign p      = SUM_W'(p_full >>> 16);
    assign s_d    = p + SUM_W'(x_q) - SUM_W'(xp_q);
    assign q_full = 37'($signed({1'b0, alpha1_q})) * 37'(s_q);
    assign q      = SUM_W'(q_full >>> 16);
    assign y_o    = y_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q      <= '0;
            xp_q     <= '0;
            yp_q     <= '0;
            alpha_q  <= '0;
            leak_q   <= '0;
            alpha1_q <= '0;
            s_q      <= '0;
            y_q      <= '0;
        end else begin
            x_q      <= x_i;
            xp_q     <= x_prev_i;
            yp_q     <= y_prev_i;
            alpha_q  <= alpha_i;
            leak_q   <= leak_i;
            alpha1_q <= alpha_q;
            s_q      <= s_d;
            y_q      <= sat16(q);
        end
    end

endmodule

// File: rtl/hpf_channel_scheduler.sv
// Sequences NUM_CHANNELS high-pass channels through one shared datapath per audio tick.
module hpf_channel_scheduler
    import hpf_sched_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS             = 4,
    parameter int unsigned CLOCK_RATE               = 50000000,
    parameter int unsigned SAMPLE_RATE              = 48000,
    parameter logic [16:0] DEFAULT_ALPHA_16_SHIFTED = 17'd65527,
    parameter logic [16:0] DEFAULT_LEAK_16_SHIFTED  = 17'd65039
) (
    input logic                     clk,
    input logic                     reset,
    hpf_channel_scheduler_if.slave  bus_io
);

    localparam int unsigned ChanW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16) begin : g_chan_check
        $error("NUM_CHANNELS must be in 1..16");
    end
    if (CYCLES_PER_CHANNEL * NUM_CHANNELS + 2 > CLOCK_RATE / SAMPLE_RATE) begin : g_rate_check
        $error("Sequence does not fit in one sample period");
    end

    state_t                     state_q, state_d;
    logic [ChanW-1:0]           chan_q;
    logic                       overrun_q;
    logic [16*NUM_CHANNELS-1:0] out_q, res_next;
    logic signed [SAMPLE_W-1:0] snap_q   [NUM_CHANNELS];
    logic signed [SAMPLE_W-1:0] x_prev_q [NUM_CHANNELS];
    logic signed [SAMPLE_W-1:0] y_prev_q [NUM_CHANNELS];
    logic [COEF_W-1:0]          alpha_sh_q [NUM_CHANNELS];
    logic [COEF_W-1:0]          leak_sh_q  [NUM_CHANNELS];
    logic [COEF_W-1:0]          alpha_q    [NUM_CHANNELS];
    logic [COEF_W-1:0]          leak_q     [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]    cfg_hit;
    logic                       tick_accept, last_chan;
    logic signed [SAMPLE_W-1:0] y;

    assign tick_accept = bus_io.audio_clk_en && (state_q == StIdle);
    assign last_chan   = (chan_q == ChanW'(NUM_CHANNELS - 1));

    always_comb begin
        cfg_hit  = '0;
        res_next = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            cfg_hit[i] = bus_io.cfg_we && (32'(bus_io.cfg_chan) == 32'(i));
            res_next[16*i +: 16] = (chan_q == ChanW'(i)) ? y : y_prev_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (tick_accept) state_d = StLoad;
            StLoad:  state_d = StMul1;
            StMul1:  state_d = StMul2;
            StMul2:  state_d = StStore;
            StStore: state_d = last_chan ? StDone : StLoad;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    hpf_update_datapath u_datapath (
        .clk      (clk),
        .reset    (reset),
        .x_i      (snap_q[chan_q]),
        .x_prev_i (x_prev_q[chan_q]),
        .y_prev_i (y_prev_q[chan_q]),
        .alpha_i  (alpha_q[chan_q]),
        .leak_i   (leak_q[chan_q]),
        .y_o      (y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            chan_q    <= '0;
            overrun_q <= 1'b0;
            out_q     <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                snap_q[i]     <= '0;
                x_prev_q[i]   <= '0;
                y_prev_q[i]   <= '0;
                alpha_sh_q[i] <= DEFAULT_ALPHA_16_SHIFTED;
                leak_sh_q[i]  <= DEFAULT_LEAK_16_SHIFTED;
                alpha_q[i]    <= DEFAULT_ALPHA_16_SHIFTED;
                leak_q[i]     <= DEFAULT_LEAK_16_SHIFTED;
            end
        end else begin
            state_q <= state_d;
            if (bus_io.audio_clk_en && (state_q != StIdle)) overrun_q <= 1'b1;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (cfg_hit[i]) begin
                    alpha_sh_q[i] <= bus_io.cfg_alpha;
                    leak_sh_q[i]  <= bus_io.cfg_leak;
                end
                // A write landing on the accepting tick bypasses straight into the active set.
                if (tick_accept) begin
                    snap_q[i]  <= bus_io.in_samples[16*i +: 16];
                    alpha_q[i] <= cfg_hit[i] ? bus_io.cfg_alpha : alpha_sh_q[i];
                    leak_q[i]  <= cfg_hit[i] ? bus_io.cfg_leak : leak_sh_q[i];
                end
            end
            if (tick_accept) chan_q <= '0;
            if (state_q == StStore) begin
                y_prev_q[chan_q] <= y;
                x_prev_q[chan_q] <= snap_q[chan_q];
                if (last_chan) out_q <= res_next;
                else chan_q <= ChanW'(chan_q + 1'b1);
            end
        end
    end

    assign bus_io.out_samples = out_q;
    assign bus_io.out_valid   = (state_q == StDone);
    assign bus_io.busy        = (state_q != StIdle) && (state_q != StDone);
    assign bus_io.overrun     = overrun_q;

endmodule

// File: tb/tb_hpf_channel_scheduler.sv
// Directed scoreboard bench for hpf_channel_scheduler with four channels.
module tb_hpf_channel_scheduler;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hpf_channel_scheduler_if #(.NUM_CHANNELS(N)) dut_if ();

    hpf_channel_scheduler #(.NUM_CHANNELS(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (dut_if)
    );

    logic [63:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int valid_count = 0;

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    // Monitor: every out_valid pops one expected output vector.
    always @(negedge clk) begin
        if (!reset && dut_if.out_valid === 1'b1) begin
            valid_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got out_samples=%h, required no out_valid",
                         dut_if.out_samples);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (dut_if.out_samples !== e) begin
                    errors++;
                    $display("FAIL out_samples: got %h, required %h", dut_if.out_samples, e);
                end
            end
        end
    end

    task automatic cfg_write(input int chan, input int alpha, input int leak);
        @(negedge clk);
        dut_if.cfg_we    = 1'b1;
        dut_if.cfg_chan  = 4'(chan);
        dut_if.cfg_alpha = 17'(alpha);
        dut_if.cfg_leak  = 17'(leak);
        @(negedge clk);
        dut_if.cfg_we    = 1'b0;
    endtask

    // Returns at the first negedge after the tick is sampled.
    task automatic tick(input logic [63:0] x);
        @(negedge clk);
        dut_if.in_samples   = x;
        dut_if.audio_clk_en = 1'b1;
        @(negedge clk);
        dut_if.audio_clk_en = 1'b0;
    endtask

    task automatic wait_valid(input int start, output int lat, output bit busy_ok);
        lat = start;
        busy_ok = 1'b1;
        while (dut_if.out_valid !== 1'b1 && lat < 40) begin
            if (dut_if.busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_tick(input logic [63:0] x, input logic [63:0] y_exp);
        int lat;
        bit busy_ok;
        exp_q.push_back(y_exp);
        tick(x);
        wait_valid(1, lat, busy_ok);
        check("latency", 64'(lat), 64'd17);
        check("busy_during_run", 64'(busy_ok), 64'd1);
        check("busy_low_at_valid", 64'(dut_if.busy), 64'd0);
        @(negedge clk);
        check("valid_one_cycle", 64'(dut_if.out_valid), 64'd0);
    endtask

    initial begin
        int lat;
        bit busy_ok;
        int vc0;
        dut_if.audio_clk_en = 1'b0;
        dut_if.in_samples   = '0;
        dut_if.cfg_we       = 1'b0;
        dut_if.cfg_chan     = '0;
        dut_if.cfg_alpha    = '0;
        dut_if.cfg_leak     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_out_samples", dut_if.out_samples, 64'd0);
        check("reset_busy", 64'(dut_if.busy), 64'd0);
        check("reset_out_valid", 64'(dut_if.out_valid), 64'd0);
        check("reset_overrun", 64'(dut_if.overrun), 64'd0);

        run_tick(64'd0, 64'd0);

        // ch0 unity differentiator, ch1 alpha=1 leak=0, ch2/ch3 keep defaults.
        cfg_write(0, 65536, 65536);
        cfg_write(1, 65536, 0);
        run_tick(pack4(0, -32768, 0, 1000), pack4(0, -32768, 0, 999));
        run_tick(pack4(1000, 32767, 0, 1000), pack4(1000, 32767, 0, 990));
        run_tick(pack4(1000, 32767, 0, 1000), pack4(1000, 0, 0, 981));

        // Overrun plus shadow write to ch2 while busy.
        exp_q.push_back(pack4(1000, 0, 999, -27));
        tick(pack4(1000, 32767, 1000, 0));
        dut_if.cfg_we    = 1'b1;
        dut_if.cfg_chan  = 4'd2;
        dut_if.cfg_alpha = 17'd65536;
        dut_if.cfg_leak  = 17'd65536;
        @(negedge clk);
        dut_if.cfg_we = 1'b0;
        repeat (3) @(negedge clk);
        dut_if.in_samples   = pack4(5000, 5000, 5000, 5000);
        dut_if.audio_clk_en = 1'b1;
        @(negedge clk);
        dut_if.audio_clk_en = 1'b0;
        check("overrun_set", 64'(dut_if.overrun), 64'd1);
        wait_valid(6, lat, busy_ok);
        check("overrun_run_latency", 64'(lat), 64'd17);
        @(negedge clk);
        check("overrun_sticky", 64'(dut_if.overrun), 64'd1);

        run_tick(pack4(1000, 32767, 2000, 0), pack4(1000, 0, 1999, -27));
        check("overrun_still_set", 64'(dut_if.overrun), 64'd1);

        // Reset mid-sequence.
        vc0 = valid_count;
        tick(pack4(1000, 0, 0, 0));
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("no_valid_after_reset", 64'(valid_count - vc0), 64'd0);
        check("midreset_busy", 64'(dut_if.busy), 64'd0);
        check("midreset_overrun", 64'(dut_if.overrun), 64'd0);
        check("midreset_out_samples", dut_if.out_samples, 64'd0);

        // Out-of-range channel write must not alias onto ch0; defaults are back.
        cfg_write(4, 65536, 65536);
        run_tick(pack4(1000, 0, 0, 0), pack4(999, 0, 0, 0));

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
